// File: rtl/bit_stream_pkg.sv
// bit_stream_pkg: types and defaults shared by the serializer and the pattern detector
package bit_stream_pkg;
  typedef enum logic {ST_IDLE, ST_SHIFT} ser_state_t;
  localparam int BS_DEFAULT_W = 8;
endpackage

// File: rtl/bit_stream_serializer_if.sv
// bit_stream_serializer_if: word handshake in, serial bit stream and status out
interface bit_stream_serializer_if import bit_stream_pkg::*; #(
  parameter int DATA_W = BS_DEFAULT_W
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              dout;
  logic              dout_valid;
  logic              busy;
  logic              word_done;
  modport master (output in_data, in_valid, input in_ready, dout, dout_valid, busy, word_done);
  modport slave  (input in_data, in_valid, output in_ready, dout, dout_valid, busy, word_done);
endinterface

// File: rtl/bit_tick_gen.sv
// bit_tick_gen: divides clk into bit periods of DIV cycles, tick on the last cycle of each
module bit_tick_gen #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  assign tick = en && cnt_q == LAST;
  always_comb cnt_d = (clr || tick) ? '0 : en ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
endmodule

// File: rtl/bit_stream_serializer.sv
// bit_stream_serializer: parallel words in on valid/ready, one bit per bit period out,
// with a one-word holding register so consecutive words stream without gap bits
module bit_stream_serializer import bit_stream_pkg::*; #(
  parameter int DATA_W    = BS_DEFAULT_W,
  parameter bit MSB_FIRST = 1'b1,
  parameter int DIV       = 1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input logic                      clk,
  input logic                      rst_n,
  bit_stream_serializer_if.slave   bus
);
  localparam int BW = $clog2(DATA_W);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);
  localparam logic [DATA_W-1:0] FILL = {DATA_W{IDLE_BIT}};
  ser_state_t        state_q, state_d;
  logic              hold_full_q, hold_full_d;
  logic [DATA_W-1:0] hold_q, hold_d, sh_q, sh_d, sh_next;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic              tick, accept, last, load;
  bit_tick_gen #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (state_q == ST_IDLE),
    .en   (state_q == ST_SHIFT),
    .tick (tick)
  );
  // the current bit always sits at the output end of the shifter, idle bits fill in behind it
  assign sh_next = MSB_FIRST ? {sh_q[DATA_W-2:0], IDLE_BIT} : {IDLE_BIT, sh_q[DATA_W-1:1]};
  always_comb begin
    accept      = bus.in_valid && !hold_full_q;
    last        = tick && bit_cnt_q == LAST_BIT;
    load        = hold_full_q && (state_q == ST_IDLE || last);
    state_d     = load ? ST_SHIFT : last ? ST_IDLE : state_q;
    hold_full_d = accept || (hold_full_q && !load);
    hold_d      = accept ? bus.in_data : hold_q;
    bit_cnt_d   = load ? '0 : tick ? (last ? '0 : bit_cnt_q + 1'b1) : bit_cnt_q;
    sh_d        = load ? hold_q : last ? FILL : tick ? sh_next : sh_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      hold_full_q <= 1'b0;
      hold_q      <= '0;
      sh_q        <= FILL;
      bit_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      hold_full_q <= hold_full_d;
      hold_q      <= hold_d;
      sh_q        <= sh_d;
      bit_cnt_q   <= bit_cnt_d;
    end
  assign bus.in_ready   = !hold_full_q;
  assign bus.dout       = MSB_FIRST ? sh_q[DATA_W-1] : sh_q[0];
  assign bus.dout_valid = state_q == ST_SHIFT;
  assign bus.busy       = state_q == ST_SHIFT || hold_full_q;
  assign bus.word_done  = last;
endmodule

// File: tb/tb_bit_stream_serializer.sv
// tb_bit_stream_serializer: directed vector table plus hand-written back-to-back and reset sequences
module tb_bit_stream_serializer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vld = 1'b0;
  logic [7:0] dat = '0;
  int         sel = 0;
  int         n_chk = 0;
  int         n_fail = 0;
  logic       o_dout, o_vld, o_rdy, o_busy, o_done;

  always #5 clk = ~clk;

  bit_stream_serializer_if #(.DATA_W(8)) if_a ();
  bit_stream_serializer_if #(.DATA_W(8)) if_b ();
  bit_stream_serializer_if #(.DATA_W(8)) if_c ();

  assign if_a.in_data  = dat;
  assign if_b.in_data  = dat;
  assign if_c.in_data  = dat;
  assign if_a.in_valid = vld && sel == 0;
  assign if_b.in_valid = vld && sel == 1;
  assign if_c.in_valid = vld && sel == 2;

  bit_stream_serializer #(.DATA_W(8), .MSB_FIRST(1'b1), .DIV(1), .IDLE_BIT(1'b0)) u_msb (
    .clk(clk), .rst_n(rst_n), .bus(if_a));
  bit_stream_serializer #(.DATA_W(8), .MSB_FIRST(1'b0), .DIV(1), .IDLE_BIT(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .bus(if_b));
  bit_stream_serializer #(.DATA_W(8), .MSB_FIRST(1'b1), .DIV(3), .IDLE_BIT(1'b0)) u_div (
    .clk(clk), .rst_n(rst_n), .bus(if_c));

  always_comb begin
    o_dout = sel == 0 ? if_a.dout       : sel == 1 ? if_b.dout       : if_c.dout;
    o_vld  = sel == 0 ? if_a.dout_valid : sel == 1 ? if_b.dout_valid : if_c.dout_valid;
    o_rdy  = sel == 0 ? if_a.in_ready   : sel == 1 ? if_b.in_ready   : if_c.in_ready;
    o_busy = sel == 0 ? if_a.busy       : sel == 1 ? if_b.busy       : if_c.busy;
    o_done = sel == 0 ? if_a.word_done  : sel == 1 ? if_b.word_done  : if_c.word_done;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int         s;
    int         dv;
    logic [7:0] word;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs[6];

  // exp holds the bits in output order, exp[7] leaves first
  task automatic send(input int s, input int dv, input logic [7:0] w, input logic [7:0] e);
    @(negedge clk);
    sel = s;
    #1;
    chk("ready_idle", 32'(o_rdy), 1);
    vld = 1'b1;
    dat = w;
    @(negedge clk);
    vld = 1'b0;
    dat = ~w;
    chk("ready_after_accept", 32'(o_rdy), 0);
    chk("valid_before_load", 32'(o_vld), 0);
    chk("busy_held", 32'(o_busy), 1);
    for (int i = 0; i < 8 * dv; i++) begin
      @(negedge clk);
      chk($sformatf("valid_c%0d", i), 32'(o_vld), 1);
      chk($sformatf("bit_c%0d", i), 32'(o_dout), 32'(e[7 - i / dv]));
      chk($sformatf("done_c%0d", i), 32'(o_done), 32'(i == 8 * dv - 1));
    end
    @(negedge clk);
    chk("valid_end", 32'(o_vld), 0);
    chk("dout_idle", 32'(o_dout), 0);
    chk("busy_end", 32'(o_busy), 0);
    chk("ready_end", 32'(o_rdy), 1);
  endtask

  initial begin
    logic [15:0] exp16;
    vecs[0] = '{0, 1, 8'b1001_0000, 8'b1001_0000};
    vecs[1] = '{0, 1, 8'h5A, 8'h5A};
    vecs[2] = '{0, 1, 8'hFF, 8'hFF};
    vecs[3] = '{1, 1, 8'h01, 8'b1000_0000};
    vecs[4] = '{1, 1, 8'hB4, 8'b0010_1101};
    vecs[5] = '{2, 3, 8'hC0, 8'hC0};

    #2;
    chk("rst_dout", 32'(o_dout), 0);
    chk("rst_valid", 32'(o_vld), 0);
    chk("rst_ready", 32'(o_rdy), 1);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_done", 32'(o_done), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[k]) send(vecs[k].s, vecs[k].dv, vecs[k].word, vecs[k].exp);

    // two words back to back with in_valid held high
    @(negedge clk);
    sel = 0;
    vld = 1'b1;
    dat = 8'hA5;
    @(negedge clk);
    chk("b2b_ready_low", 32'(o_rdy), 0);
    dat = 8'h3C;
    exp16 = 16'hA53C;
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      if (j == 0) chk("b2b_ready_back", 32'(o_rdy), 1);
      if (j == 1) begin
        vld = 1'b0;
        chk("b2b_ready_held", 32'(o_rdy), 0);
      end
      chk($sformatf("b2b_valid_%0d", j), 32'(o_vld), 1);
      chk($sformatf("b2b_bit_%0d", j), 32'(o_dout), 32'(exp16[15 - j]));
      chk($sformatf("b2b_done_%0d", j), 32'(o_done), 32'(j == 7 || j == 15));
    end
    @(negedge clk);
    chk("b2b_valid_end", 32'(o_vld), 0);
    chk("b2b_busy_end", 32'(o_busy), 0);

    // reset during bit 3 with a second word waiting in the hold register
    @(negedge clk);
    vld = 1'b1;
    dat = 8'hFF;
    @(negedge clk);
    dat = 8'h0F;
    @(negedge clk);
    @(negedge clk);
    vld = 1'b0;
    chk("mid_hold_full", 32'(o_rdy), 0);
    @(negedge clk);
    @(negedge clk);
    chk("mid_bit3", 32'(o_dout), 1);
    chk("mid_valid3", 32'(o_vld), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_dout", 32'(o_dout), 0);
    chk("arst_valid", 32'(o_vld), 0);
    chk("arst_ready", 32'(o_rdy), 1);
    chk("arst_busy", 32'(o_busy), 0);
    chk("arst_done", 32'(o_done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_valid", 32'(o_vld), 0);
      chk("post_rst_busy", 32'(o_busy), 0);
    end
    send(0, 1, 8'h81, 8'h81);

    // line stays idle with no new word
    repeat (3) begin
      @(negedge clk);
      chk("idle_dout", 32'(o_dout), 0);
      chk("idle_valid", 32'(o_vld), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
